// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: opcodes, FSM states and the latched command.
package counter_seq_pkg;

  // Widest per-command step count the command struct can carry.
  localparam int MAX_STEP_W = 32;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    op_e                   op;
    logic [MAX_STEP_W-1:0] steps;
  } cmd_t;

  function automatic logic is_moving(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first request at or after the pointer wins; the pointer
// moves past the winner when the grant is accepted.
module rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             accept,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // NOTE: every variable is given a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Arbitrates up/down/hold commands from NREQ requesters onto the shared counter and
// reports final count, predicted-vs-actual error and boundary wrap for each command.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NREQ   = 2,
  parameter  int STEP_W = 8,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*2-1:0]        req_op,
  input  logic [NREQ*STEP_W-1:0]   req_steps,
  input  logic [WIDTH-1:0]         count_out,
  output logic                     cnt_en,
  output logic                     cnt_mode,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [WIDTH-1:0]         done_count,
  output logic                     done_err,
  output logic                     done_wrap
);

  localparam int SUM_W = WIDTH + STEP_W;

  state_e              state_q, state_d;
  cmd_t                cmd_q;
  logic [ID_W-1:0]     id_q;
  logic [WIDTH-1:0]    exp_q;
  logic                wrap_q;
  logic                mode_q;

  logic [ID_W-1:0]     done_id_q;
  logic [WIDTH-1:0]    done_count_q;
  logic                done_err_q;
  logic                done_wrap_q;

  logic [NREQ-1:0]     arb_req;
  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     grant_idx;
  logic                accept;
  op_e                 sel_op;
  logic [STEP_W-1:0]   sel_steps;
  logic [SUM_W-1:0]    up_sum;
  logic [WIDTH-1:0]    exp_d;
  logic                wrap_d;
  logic                err_live;

  assign arb_req   = req_valid & {NREQ{state_q == IDLE}};
  assign req_ready = grant;
  assign accept    = |grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Prediction is formed in WIDTH+STEP_W bits so step counts beyond 2^WIDTH still flag wrap.
  always_comb begin
    sel_op    = op_e'(req_op[int'(grant_idx)*2 +: 2]);
    sel_steps = req_steps[int'(grant_idx)*STEP_W +: STEP_W];
    up_sum    = SUM_W'(count_out) + SUM_W'(sel_steps);
    exp_d     = count_out;
    wrap_d    = 1'b0;
    case (sel_op)
      OP_UP: begin
        exp_d  = up_sum[WIDTH-1:0];
        wrap_d = |up_sum[SUM_W-1:WIDTH];
      end
      OP_DOWN: begin
        exp_d  = count_out - WIDTH'(sel_steps);
        wrap_d = SUM_W'(sel_steps) > SUM_W'(count_out);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (sel_steps == '0) ? DONE : RUN;
      RUN:     if (cmd_q.steps == MAX_STEP_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '{op: OP_HOLD, steps: '0};
      id_q         <= '0;
      exp_q        <= '0;
      wrap_q       <= 1'b0;
      mode_q       <= 1'b1;
      done_id_q    <= '0;
      done_count_q <= '0;
      done_err_q   <= 1'b0;
      done_wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q.op    <= sel_op;
        cmd_q.steps <= MAX_STEP_W'(sel_steps);
        id_q        <= grant_idx;
        exp_q       <= exp_d;
        wrap_q      <= wrap_d;
        if (sel_op == OP_UP)   mode_q <= 1'b1;
        if (sel_op == OP_DOWN) mode_q <= 1'b0;
      end else if (state_q == RUN) begin
        cmd_q.steps <= cmd_q.steps - MAX_STEP_W'(1);
      end
      // Result is live during DONE and frozen here for the idle cycles that follow.
      if (state_q == DONE) begin
        done_id_q    <= id_q;
        done_count_q <= count_out;
        done_err_q   <= err_live;
        done_wrap_q  <= wrap_q;
      end
    end
  end

  assign err_live   = (count_out != exp_q) || (cmd_q.op == OP_RSVD);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign cnt_en     = (state_q == RUN) && is_moving(cmd_q.op);
  assign cnt_mode   = mode_q;
  assign done_id    = done ? id_q      : done_id_q;
  assign done_count = done ? count_out : done_count_q;
  assign done_err   = done ? err_live  : done_err_q;
  assign done_wrap  = done ? wrap_q    : done_wrap_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: a behavioural counter drives count_out, a
// timeline model predicts every output each cycle, and directed tests pin literal results.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int WIDTH  = 8;
  localparam int NREQ   = 2;
  localparam int STEP_W = 8;
  localparam int ID_W   = 1;
  localparam int MOD    = 1 << WIDTH;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*2-1:0]      req_op = '0;
  logic [NREQ*STEP_W-1:0] req_steps = '0;
  logic [WIDTH-1:0]       count_out;
  logic                   cnt_en, cnt_mode, busy, done, done_err, done_wrap;
  logic [ID_W-1:0]        done_id;
  logic [WIDTH-1:0]       done_count;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(WIDTH), .NREQ(NREQ), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_steps  (req_steps),
    .count_out  (count_out),
    .cnt_en     (cnt_en),
    .cnt_mode   (cnt_mode),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .done_count (done_count),
    .done_err   (done_err),
    .done_wrap  (done_wrap)
  );

  // Shared up/down counter, with a load port and a stuck-at switch for fault tests.
  logic             load_req = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             stuck = 1'b0;
  logic [WIDTH-1:0] cnt = '0;
  always @(posedge clk) begin
    if (load_req)              cnt <= load_val;
    else if (cnt_en && !stuck) cnt <= cnt_mode ? cnt + 1'b1 : cnt - 1'b1;
  end
  assign count_out = cnt;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s cyc=%0d timed out", name, cyc);
  endtask

  // Timeline model: a command accepted in cycle a with N steps enables in a+1..a+N
  // and reports in a+N+1; nothing is derived from DUT state.
  bit m_known = 0, m_active = 0, m_mode = 1;
  int m_acc, m_n, m_op, m_id, m_start, m_ptr = 0;
  int h_id = 0, h_count = 0, h_err = 0, h_wrap = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] e_ready;
    int g, k, ev, e_id, e_count, e_err, e_wrap;
    bit e_busy, e_en, e_done, ew;
    e_ready = '0; e_busy = 0; e_en = 0; e_done = 0; g = -1;
    e_id = h_id; e_count = h_count; e_err = h_err; e_wrap = h_wrap;
    if (!m_active) begin
      for (int j = 0; j < NREQ; j++) begin
        int i;
        i = (m_ptr + j) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
      if (g >= 0) e_ready[g] = 1'b1;
    end else begin
      k = cyc - m_acc;
      e_busy = 1;
      if (k <= m_n) begin
        e_en = (m_op == 1) || (m_op == 2);
      end else begin
        e_done = 1;
        case (m_op)
          1:       begin ev = (m_start + m_n) % MOD;             ew = (m_start + m_n) > MOD - 1; end
          2:       begin ev = ((m_start - m_n) % MOD + MOD) % MOD; ew = m_n > m_start;         end
          default: begin ev = m_start;                            ew = 0;                       end
        endcase
        e_id = m_id; e_count = int'(count_out);
        e_err = ((int'(count_out) != ev) || (m_op == 3)) ? 1 : 0;
        e_wrap = ew ? 1 : 0;
      end
    end
    if (m_known) begin
      check("m_ready", req_ready, e_ready);
      check("m_busy", busy, e_busy);
      check("m_en", cnt_en, e_en);
      check("m_mode", cnt_mode, m_mode);
      check("m_done", done, e_done);
      check("m_done_id", done_id, e_id);
      check("m_done_count", done_count, e_count);
      check("m_done_err", done_err, e_err);
      check("m_done_wrap", done_wrap, e_wrap);
    end
    if (rst) begin
      m_known = 1; m_active = 0; m_ptr = 0; m_mode = 1;
      h_id = 0; h_count = 0; h_err = 0; h_wrap = 0;
    end else if (m_known) begin
      if (!m_active && g >= 0) begin
        m_active = 1; m_acc = cyc; m_id = g;
        m_op = int'(req_op[g*2 +: 2]);
        m_n = int'(req_steps[g*STEP_W +: STEP_W]);
        m_start = int'(count_out);
        m_ptr = (g + 1) % NREQ;
        if (m_op == 1) m_mode = 1;
        if (m_op == 2) m_mode = 0;
      end else if (m_active && (cyc - m_acc) == m_n + 1) begin
        m_active = 0;
        h_id = e_id; h_count = e_count; h_err = e_err; h_wrap = e_wrap;
      end
    end
  end

  task automatic drive(input int id, input int op, input int n);
    req_op[id*2 +: 2] = 2'(op);
    req_steps[id*STEP_W +: STEP_W] = STEP_W'(n);
    req_valid[id] = 1'b1;
  endtask

  task automatic load_count(input int v);
    @(posedge clk); #1;
    load_req = 1'b1; load_val = WIDTH'(v);
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Issues one command and returns at the negedge of its DONE cycle.
  task automatic run_cmd(input int id, input int op, input int n,
                         output int acc, output int dn, output int en_cnt);
    @(posedge clk); #1;
    drive(id, op, n);
    acc = -1;
    for (int t = 0; t < 40 && acc < 0; t++) begin
      @(negedge clk);
      if (req_ready[id]) acc = cyc;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (acc < 0) timeout("accept");
    dn = -1; en_cnt = 0;
    for (int t = 0; t < 300 && dn < 0; t++) begin
      @(negedge clk);
      if (cnt_en) en_cnt++;
      if (done) dn = cyc;
    end
    if (dn < 0) timeout("done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, dn, en, start;
    int ids[4];
    int dcyc[4];
    int got;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_en", cnt_en, 0);
    check("rst_mode", cnt_mode, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_done_count", done_count, 0);
    check("rst_done_err", done_err, 0);
    check("rst_done_wrap", done_wrap, 0);

    // 1: UP 5 from 0
    run_cmd(0, 1, 5, acc, dn, en);
    check("t1_en_cycles", en, 5);
    check("t1_latency", dn - acc, 6);
    check("t1_count", done_count, 5);
    check("t1_err", done_err, 0);
    check("t1_wrap", done_wrap, 0);
    check("t1_id", done_id, 0);

    // 2: DOWN 3 from 1 wraps to 254
    load_count(1);
    run_cmd(1, 2, 3, acc, dn, en);
    check("t2_count", done_count, 254);
    check("t2_wrap", done_wrap, 1);
    check("t2_err", done_err, 0);
    check("t2_id", done_id, 1);

    // 3: both requesters stream UP 1
    @(posedge clk); #1;
    drive(0, 1, 1);
    drive(1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      dcyc[i] = -1;
      for (int t = 0; t < 20 && dcyc[i] < 0; t++) begin
        @(negedge clk);
        if (done) begin dcyc[i] = cyc; ids[i] = int'(done_id); end
      end
      if (dcyc[i] < 0) timeout("t3_done");
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      check("t3_id", ids[i], i % 2);
      if (i > 0) check("t3_spacing", dcyc[i] - dcyc[i-1], 3);
    end

    // 4: HOLD 4, UP 0, reserved op 2; count sits at 2
    run_cmd(0, 0, 4, acc, dn, en);
    check("t4_hold_en", en, 0);
    check("t4_hold_latency", dn - acc, 5);
    check("t4_hold_count", done_count, 2);
    run_cmd(0, 1, 0, acc, dn, en);
    check("t4_n0_en", en, 0);
    check("t4_n0_latency", dn - acc, 1);
    check("t4_n0_err", done_err, 0);
    run_cmd(0, 3, 2, acc, dn, en);
    check("t4_rsvd_en", en, 0);
    check("t4_rsvd_err", done_err, 1);
    check("t4_rsvd_count", done_count, 2);

    // 5: stuck counter disagrees with prediction
    load_count(7);
    stuck = 1'b1;
    run_cmd(0, 1, 1, acc, dn, en);
    check("t5_err", done_err, 1);
    check("t5_count", done_count, 7);
    stuck = 1'b0;

    // 6: reset in the middle of UP 10
    @(posedge clk); #1;
    drive(0, 1, 10);
    acc = -1;
    for (int t = 0; t < 20 && acc < 0; t++) begin
      @(negedge clk);
      if (req_ready[0]) acc = cyc;
    end
    if (acc < 0) timeout("t6_accept");
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_en_after_rst", cnt_en, 0);
    check("t6_busy_after_rst", busy, 0);
    got = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done) got++;
    end
    check("t6_no_done", got, 0);
    @(posedge clk); #1;
    drive(0, 1, 2);
    drive(1, 1, 2);
    @(negedge clk);
    check("t6_ptr_reset", req_ready, 2'b01);
    start = int'(count_out);
    @(posedge clk); #1;
    req_valid = '0;
    dn = -1;
    for (int t = 0; t < 20 && dn < 0; t++) begin
      @(negedge clk);
      if (done) dn = cyc;
    end
    if (dn < 0) timeout("t6_done");
    check("t6_id", done_id, 0);
    check("t6_count", done_count, (start + 2) % MOD);
    check("t6_err", done_err, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Sequences the shared up/down counter (`counter_dut`: `en`, `mode`, `count_out`) on behalf of NREQ requesters.
- Round-robin arbitration picks one command at a time.
- Each command is UP, DOWN or HOLD for N cycles. The block drives the counter's `en`/`mode` for exactly N cycles.
- On completion it reports the final count, a predicted-vs-actual mismatch flag and a wrap flag.
- Sits between test/control logic and the counter. It does not drive the counter's reset.

Parameters:
- WIDTH, 8: counter width; matches the counter's `count_out`.
- NREQ, 2: number of requesters (at least 2).
- STEP_W, 8: width of the per-command step count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_op  in  NREQ*2  per-requester opcode: 00 HOLD, 01 UP, 10 DOWN, 11 reserved.
- req_steps  in  NREQ*STEP_W  per-requester cycle count N.
- count_out  in  WIDTH  current counter value.
- cnt_en  out  1  counter enable.
- cnt_mode  out  1  counter direction: 1 up, 0 down.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  single-cycle completion pulse.
- done_id  out  $clog2(NREQ)  requester index of the completed command.
- done_count  out  WIDTH  count_out sampled in the DONE cycle.
- done_err  out  1  count_out differs from predicted value, or opcode 11 was issued.
- done_wrap  out  1  the command crossed the 0 / 2^WIDTH-1 boundary.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, rr pointer=0, command dropped.
  - cnt_en=0, cnt_mode=1, busy=0, done=0, done_id=0, done_count=0, done_err=0, done_wrap=0.
- Reset mid-command: no done is issued and cnt_en drops at that edge.
- State machine:
  - IDLE -> RUN (N>0) or DONE (N=0) on handshake.
  - RUN -> DONE when the remaining-step counter reaches 1 after its final enable cycle.
  - DONE -> IDLE unconditionally.
- Arbitration, IDLE only:
  - req_ready is combinational.
  - The first valid index at or after the rr pointer (wrapping modulo NREQ) gets ready=1.
  - Handshake = valid & ready. After granting i, pointer = (i+1) mod NREQ.
  - req_ready=0 in RUN and DONE.
  - Requesters hold op/steps stable while valid is high and not yet accepted.
- Accept cycle A registers:
  - op, steps, id.
  - start = count_out.
  - expected value:
    - UP: start+N mod 2^WIDTH.
    - DOWN: start−N mod 2^WIDTH.
    - HOLD/11: start.
  - wrap:
    - UP: start+N > 2^WIDTH−1.
    - DOWN: N > start.
    - otherwise 0.
  - Arithmetic is done in WIDTH+STEP_W bits, so N ≥ 2^WIDTH is handled.
- RUN, cycles A+1 .. A+N:
  - cnt_en=1 for UP/DOWN; cnt_en=0 for HOLD/11.
  - cnt_mode=1 for UP, 0 for DOWN, constant for the whole command.
  - For HOLD/11, cnt_mode keeps its previous value.
- DONE, cycle A+N+1:
  - done=1, done_id=id, done_count=count_out, done_wrap=wrap.
  - done_err = (count_out≠expected) | (op==11).
  - cnt_en=0.
- done_* outputs hold their values until the next DONE. done itself is a pulse.
- Latency and throughput:
  - N=0 gives done at A+1 with no enable cycles.
  - The next handshake is possible at A+N+2, i.e. throughput is N+2 cycles per command.
- Simultaneous valids from all requesters are served in rotating order; no requester waits more than NREQ−1 commands.
- A requester that drops valid before ready is simply skipped.

Decomposition:
- Package `counter_seq_pkg` holds:
  - op enum (OP_HOLD, OP_UP, OP_DOWN, OP_RSVD);
  - state enum (IDLE, RUN, DONE);
  - a typedef for the command struct {op, steps}.
- One sub-module, `rr_arbiter`: NREQ-wide request in, one-hot grant out, pointer update on an `accept` input.

Test Plan:
1. Reset, then requester 0 issues UP N=5 with count_out=0.
   - cnt_en high exactly 5 cycles, cnt_mode=1.
   - done at A+6 with done_count=5, done_err=0, done_wrap=0.
2. Requester 1 issues DOWN N=3 from count 1.
   - done_count=254, done_wrap=1, done_err=0.
3. Both requesters hold valid continuously with UP N=1.
   - Grants alternate 0,1,0,1; done_id alternates.
   - Commands are spaced exactly 3 cycles apart.
4. HOLD N=4, then UP N=0, then op 11 N=2.
   - cnt_en stays 0 throughout.
   - N=0 gives done at A+1.
   - op 11 gives done_err=1 with the count unchanged.
5. Counter is forced to disagree: a stuck-at model returns count_out=7 where 8 is expected after UP N=1 from 7.
   - done_err=1.
6. rst pulsed in the middle of UP N=10.
   - cnt_en=0 and busy=0 the next cycle, no done, rr pointer back to 0.
   - A fresh command then completes normally.
